bk_adder_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 12-bit combinational Brent-Kung adder.
- Same interleaved operand bus (INPUTS) and sum-plus-carry result bus (OUTS).
- Adds: configurable width, configurable pipeline depth, add/subtract mode with carry-in, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits between operand-producing datapath stages and result consumers.

---
 rtl/bk_adder_pipe.sv | 155 +++++++++++++++
 tb/tb_bk_adder_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with interleaved operand bus and valid/ready flow control.
// Pipeline registers sit between prefix levels; the last stage always registers the result.
module bk_adder_pipe #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] INPUTS,
    input  logic               mode,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     OUTS,
    output logic               ovf,
    output logic               zero
);

    localparam int unsigned K = $clog2(WIDTH);
    localparam int unsigned N = 32'(1) << K;
    localparam int unsigned L = 2 * K - 1;

    // Side-band carried alongside the prefix vectors to the sum stage
    typedef struct packed {
        logic [WIDTH-1:0] p0;
        logic             c;
        logic             a_msb;
        logic             b_msb;
    } side_t;

    // Internal register j sits after prefix level floor(j*(L+1)/STAGES)
    function automatic logic is_cut(input int unsigned lv);
        logic hit;
        hit = 1'b0;
        for (int unsigned j = 1; j < STAGES; j++) begin
            if ((j * (L + 1)) / STAGES == lv) hit = 1'b1;
        end
        return hit;
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
        logic [N-1:0] cur_g;
        logic [N-1:0] cur_p;
        side_t        cur_s;
        logic         cur_v;

        if (lv == 0) begin : g_gp
            logic [WIDTH-1:0] op_a;
            logic [WIDTH-1:0] op_b;
            logic [WIDTH-1:0] eff_b;
            logic             c0;

            for (genvar i = 0; i < WIDTH; i++) begin : g_unpack
                assign op_a[i] = INPUTS[2*i];
                assign op_b[i] = INPUTS[2*i+1];
            end

            assign eff_b = mode ? ~op_b : op_b;
            assign c0    = mode | cin;
            // Carry-in folds into bit 0's generate so the tree yields true carries
            assign cur_p = N'(op_a ^ eff_b);
            assign cur_g = N'(op_a & eff_b) | N'((op_a[0] ^ eff_b[0]) & c0);
            assign cur_s = '{p0: op_a ^ eff_b, c: c0, a_msb: op_a[WIDTH-1], b_msb: eff_b[WIDTH-1]};
            assign cur_v = in_valid;
        end else begin : g_pf
            localparam int unsigned LV = 32'(lv);
            localparam logic        UP = (LV <= K);
            localparam int unsigned S  = UP ? (32'(1) << (LV - 1)) : (32'(1) << (2 * K - 1 - LV));

            logic [N-1:0] prv_g;
            logic [N-1:0] prv_p;
            side_t        prv_s;
            logic         prv_v;
            logic [N-1:0] nxt_g;
            logic [N-1:0] nxt_p;

            assign prv_g = g_lvl[lv-1].cur_g;
            assign prv_p = g_lvl[lv-1].cur_p;
            assign prv_s = g_lvl[lv-1].cur_s;
            assign prv_v = g_lvl[lv-1].cur_v;

            for (genvar i = 0; i < N; i++) begin : g_bit
                localparam int unsigned P = 32'(i) + 1;
                if (UP ? (P % (2 * S) == 0) : ((P % (2 * S) == S) && (P >= 3 * S))) begin : g_node
                    assign nxt_g[i] = prv_g[i] | (prv_p[i] & prv_g[i-S]);
                    assign nxt_p[i] = prv_p[i] & prv_p[i-S];
                end else begin : g_pass
                    assign nxt_g[i] = prv_g[i];
                    assign nxt_p[i] = prv_p[i];
                end
            end

            if (is_cut(LV)) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cur_g <= '0;
                        cur_p <= '0;
                        cur_s <= '0;
                        cur_v <= 1'b0;
                    end else if (advance) begin
                        cur_g <= nxt_g;
                        cur_p <= nxt_p;
                        cur_s <= prv_s;
                        cur_v <= prv_v;
                    end
                end
            end else begin : g_thru
                assign cur_g = nxt_g;
                assign cur_p = nxt_p;
                assign cur_s = prv_s;
                assign cur_v = prv_v;
            end
        end
    end

    logic [N-1:0]     fin_g;
    logic [N-1:0]     fin_p;
    side_t            fin_s;
    logic             fin_v;
    logic [WIDTH-1:0] carries;
    logic [WIDTH-1:0] sum_c;
    logic             unused_prefix;

    assign fin_g   = g_lvl[L].cur_g;
    assign fin_p   = g_lvl[L].cur_p;
    assign fin_s   = g_lvl[L].cur_s;
    assign fin_v   = g_lvl[L].cur_v;
    assign carries = {fin_g[WIDTH-2:0], fin_s.c};
    assign sum_c   = fin_s.p0 ^ carries;
    assign unused_prefix = ^{fin_g, fin_p};

    // Output stage: result fields load only when a valid result arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            OUTS      <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= fin_v;
            if (fin_v) begin
                OUTS <= {fin_g[WIDTH-1], sum_c};
                ovf  <= (fin_s.a_msb == fin_s.b_msb) && (sum_c[WIDTH-1] != fin_s.a_msb);
                zero <= (sum_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed corner cases, flow control, reset, random traffic.
module tb_bk_adder_pipe;

    localparam int unsigned W  = 12;
    localparam int unsigned ST = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   INPUTS;
    logic             mode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       OUTS;
    logic             ovf;
    logic             zero;

    always #5 clk = ~clk;

    bk_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .INPUTS   (INPUTS),
        .mode     (mode),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .OUTS     (OUTS),
        .ovf      (ovf),
        .zero     (zero)
    );

    typedef struct packed {
        logic [W:0] outs;
        logic       ovf;
        logic       zero;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic         c;
    } op_t;

    exp_t         exp_q[$];
    op_t          send_q[$];
    int           compared   = 0;
    int           mismatched = 0;
    int           delivered  = 0;
    logic         last_fire;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;

    // Reference: plain integer arithmetic on signed/unsigned operand values
    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic m, input logic c);
        exp_t   e;
        longint ua, ub, us, sa, sb, sr, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb  = b[W-1] ? ub - (longint'(1) << W) : ub;
        lim = longint'(1) << (W - 1);
        if (m) begin
            us = ua - ub + (longint'(1) << W);
            sr = sa - sb;
        end else begin
            us = ua + ub + longint'(c);
            sr = sa + sb + longint'(c);
        end
        e.outs = (W+1)'(us);
        e.ovf  = (sr < -lim) || (sr >= lim);
        e.zero = ((us % (longint'(1) << W)) == 0);
        return e;
    endfunction

    function automatic logic [2*W-1:0] pack_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        for (int i = 0; i < int'(W); i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = W'($urandom);
        o.b = W'($urandom);
        o.m = 1'($urandom_range(0, 1));
        o.c = 1'($urandom_range(0, 1));
        return o;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input op_t o);
        cur_a  = o.a;
        cur_b  = o.b;
        INPUTS = pack_ops(o.a, o.b);
        mode   = o.m;
        cin    = o.c;
    endtask

    // One cycle: score outputs and inputs that transfer at the coming edge
    task automatic tick();
        exp_t e;
        #1;
        last_fire = 1'b0;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL out_unexpected: observed result %0h expected no result", OUTS);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                delivered++;
                check("sb_outs", 65'(OUTS), 65'(e.outs));
                check("sb_ovf",  65'(ovf),  65'(e.ovf));
                check("sb_zero", 65'(zero), 65'(e.zero));
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            exp_q.push_back(ref_model(cur_a, cur_b, mode, cin));
            last_fire = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present();
        if (send_q.size() != 0) begin
            set_op(send_q[0]);
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_cycle();
        present();
        tick();
        if (last_fire && send_q.size() != 0) void'(send_q.pop_front());
    endtask

    // Single isolated operation with latency and explicit result checks
    task automatic single(input string tag, input op_t o, input logic [W:0] x_outs,
                          input logic x_ovf, input logic x_zero);
        set_op(o);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= int'(ST); k++) begin
            if (k > 1) tick();
            check({tag, "_valid"}, 65'(out_valid), 65'(k == int'(ST)));
        end
        check({tag, "_outs"}, 65'(OUTS), 65'(x_outs));
        check({tag, "_ovf"},  65'(ovf),  65'(x_ovf));
        check({tag, "_zero"}, 65'(zero), 65'(x_zero));
        tick();
    endtask

    initial begin
        logic [W-1:0] ones, msb, alt;
        op_t          o;
        int           base;

        ones = '1;
        msb  = W'(1) << (W - 1);
        for (int i = 0; i < int'(W); i++) alt[i] = (i % 2 == 0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        INPUTS = '0; mode = 1'b0; cin = 1'b0; cur_a = '0; cur_b = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 65'(out_valid), 65'(0));
        check("rst_outs",      65'(OUTS),      65'(0));
        check("rst_ovf",       65'(ovf),       65'(0));
        check("rst_zero",      65'(zero),      65'(0));
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 65'(in_ready), 65'(1));

        o = '{a: ones, b: W'(1), m: 1'b0, c: 1'b0};
        single("add_wrap", o, {1'b1, W'(0)}, 1'b0, 1'b1);
        o = '{a: W'(0), b: W'(1), m: 1'b1, c: 1'b0};
        single("sub_borrow", o, {1'b0, ones}, 1'b0, 1'b0);
        o = '{a: msb, b: W'(1), m: 1'b1, c: 1'b0};
        single("sub_ovf", o, {1'b1, msb - W'(1)}, 1'b1, 1'b0);
        o = '{a: msb - W'(1), b: W'(1), m: 1'b0, c: 1'b1};
        single("add_ovf_cin", o, {1'b0, msb | W'(1)}, 1'b1, 1'b0);
        o = '{a: alt, b: ~alt, m: 1'b0, c: 1'b1};
        single("add_alt_cin", o, {1'b1, W'(0)}, 1'b0, 1'b1);
        o = '{a: W'(5), b: W'(3), m: 1'b1, c: 1'b1};
        single("sub_cin_ignored", o, {1'b1, W'(2)}, 1'b0, 1'b0);

        // Full rate: one result per cycle once the pipe has filled
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            set_op(rand_op());
            in_valid = 1'b1;
            tick();
            check("fullrate_valid", 65'(out_valid), 65'((c + 1) >= int'(ST)));
            check("fullrate_ready", 65'(in_ready),  65'(1));
        end
        in_valid = 1'b0;
        repeat (ST + 2) tick();
        check("fullrate_drained", 65'(exp_q.size()), 65'(0));

        // Backpressure: fill with out_ready low, hold, then drain in order
        out_ready = 1'b0;
        base = delivered;
        for (int n = 0; n < int'(ST) + 1; n++) send_q.push_back(rand_op());
        repeat (ST) run_cycle();
        check("bp_pending", 65'(send_q.size()), 65'(1));
        for (int c = 0; c < 4; c++) begin
            present();
            #1;
            check("bp_in_ready",  65'(in_ready),  65'(0));
            check("bp_out_valid", 65'(out_valid), 65'(1));
            check("bp_hold_outs", 65'(OUTS),      65'(exp_q[0].outs));
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (send_q.size() != 0 || exp_q.size() != 0); c++) run_cycle();
        check("bp_delivered", 65'(delivered - base), 65'(ST + 1));

        // Reset with operations in flight
        send_q.push_back(rand_op());
        send_q.push_back(rand_op());
        run_cycle();
        run_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 65'(out_valid), 65'(0));
        check("midrst_outs",      65'(OUTS),      65'(0));
        check("midrst_ovf",       65'(ovf),       65'(0));
        exp_q.delete();
        send_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 65'(in_ready), 65'(1));
        repeat (2 * ST + 4) begin
            tick();
            check("midrst_no_output", 65'(out_valid), 65'(0));
        end

        // Random traffic with random producer and consumer stalls
        for (int c = 0; c < 6000; c++) begin
            set_op(rand_op());
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
        check("rand_drained", 65'(exp_q.size()), 65'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
